// File: rtl/wasca_pwm_leds_pkg.sv
// ---------------------------------------------------------------------------
// wasca_pwm_leds_pkg
// Shared definitions for the WASCA PWM LED block.
//   - Avalon-MM word addresses of the register map
//   - Default values for the block parameters
// ---------------------------------------------------------------------------
package wasca_pwm_leds_pkg;

    // Register map (word addresses on the 3-bit Avalon-MM address bus)
    localparam logic [2:0] ADDR_DATA   = 3'd0;  // RW  LED on/off pattern
    localparam logic [2:0] ADDR_SET    = 3'd1;  // WO  write-1-to-set DATA
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;  // WO  write-1-to-clear DATA
    localparam logic [2:0] ADDR_MODE   = 3'd3;  // RW  per channel: 0 steady, 1 blink
    localparam logic [2:0] ADDR_PERIOD = 3'd4;  // RW  blink half-period in ticks
    localparam logic [2:0] ADDR_DUTY   = 3'd5;  // RW  global PWM brightness

    // Default parameter values
    localparam int DEF_NUM_LEDS = 5;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_PRESCALE = 50000;

    // Width of the PERIOD register
    localparam int PERIOD_BITS = 16;

endpackage : wasca_pwm_leds_pkg

// File: rtl/wasca_led_pwm_gen.sv
// ---------------------------------------------------------------------------
// wasca_led_pwm_gen
// Timing generator shared by all LED channels.
//   - Prescaler: counts 0..PRESCALE-1, tick is high while it sits at the top.
//   - Blink counter / phase: phase toggles every PERIOD ticks; PERIOD=0 holds
//     phase at 1.
//   - PWM counter: free-running; pwm_on compares it against DUTY.
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   period     in   current PERIOD register value
//   period_wr  in   PERIOD is being written this cycle (restart blink timing)
//   duty       in   current DUTY register value
//   tick       out  one-cycle blink tick
//   phase      out  blink phase (1 = lit half)
//   pwm_on     out  PWM gate for this cycle
// ---------------------------------------------------------------------------
module wasca_led_pwm_gen
    import wasca_pwm_leds_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   period_wr,
    input  logic [PWM_BITS-1:0]    duty,
    output logic                   tick,
    output logic                   phase,
    output logic                   pwm_on
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]        presc_q, presc_d;
    logic [PERIOD_BITS-1:0] blink_q, blink_d;
    logic                   phase_q, phase_d;
    logic [PWM_BITS-1:0]    pwm_cnt_q;

    assign tick   = (presc_q == PS_W'(PRESCALE - 1));
    assign phase  = phase_q;
    // All-ones duty means fully on; otherwise a strict compare gives
    // duty/2^PWM_BITS on-time and duty=0 never lights.
    assign pwm_on = (&duty) | (pwm_cnt_q < duty);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        blink_d = blink_q;
        phase_d = phase_q;
        if (period == '0) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (tick) begin
            if (blink_q == period - PERIOD_BITS'(1)) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + PERIOD_BITS'(1);
            end
        end
        // A new period restarts blinking from the lit half right away.
        if (period_wr) begin
            presc_d = '0;
            blink_d = '0;
            phase_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

endmodule : wasca_led_pwm_gen

// File: rtl/wasca_pwm_leds.sv
// ---------------------------------------------------------------------------
// wasca_pwm_leds
// Avalon-MM LED controller with per-channel blink and global PWM dimming.
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   address     in   word address (DATA, SET, CLEAR, MODE, PERIOD, DUTY)
//   chipselect  in   slave select
//   write_n     in   write strobe, active-low
//   writedata   in   write data
//   readdata    out  read data, combinational from address, unused bits 0
//   out_port    out  registered LED drive, 1 = lit
// ---------------------------------------------------------------------------
module wasca_pwm_leds
    import wasca_pwm_leds_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] out_port
);

    logic [NUM_LEDS-1:0]    data_q, data_d;
    logic [NUM_LEDS-1:0]    mode_q, mode_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic [PWM_BITS-1:0]    duty_q, duty_d;
    logic [NUM_LEDS-1:0]    out_q, out_d;

    logic wr_en;
    logic period_wr;
    logic phase;
    logic pwm_on;
    logic unused_tick;
    logic unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign period_wr = wr_en && (address == ADDR_PERIOD);

    // No register is wider than 16 bits.
    assign unused_wdata = &{1'b0, writedata[31:16]};

    wasca_led_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (period_q),
        .period_wr (period_wr),
        .duty      (duty_q),
        .tick      (unused_tick),
        .phase     (phase),
        .pwm_on    (pwm_on)
    );

    // Register write decode
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d   = writedata[NUM_LEDS-1:0];
                ADDR_SET:    data_d   = data_q | writedata[NUM_LEDS-1:0];
                ADDR_CLEAR:  data_d   = data_q & ~writedata[NUM_LEDS-1:0];
                ADDR_MODE:   mode_d   = writedata[NUM_LEDS-1:0];
                ADDR_PERIOD: period_d = writedata[PERIOD_BITS-1:0];
                ADDR_DUTY:   duty_d   = writedata[PWM_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Blink channels are gated by the shared phase; everything by PWM.
    assign out_d = data_q & (~mode_q | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            mode_q   <= '0;
            period_q <= '0;
            duty_q   <= '1;
            out_q    <= '0;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            out_q    <= out_d;
        end
    end

    assign out_port = out_q;

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[NUM_LEDS-1:0]    = data_q;
            ADDR_MODE:   readdata[NUM_LEDS-1:0]    = mode_q;
            ADDR_PERIOD: readdata[PERIOD_BITS-1:0] = period_q;
            ADDR_DUTY:   readdata[PWM_BITS-1:0]    = duty_q;
            default:     readdata = '0;
        endcase
    end

endmodule : wasca_pwm_leds

// File: doc/wasca_pwm_leds.md
WASCA_PWM_LEDS -- requirements
Module: wasca_pwm_leds

Interface
REQ-001 Parameter NUM_LEDS, default 5, LED channel count (1..16).
REQ-002 Parameter PWM_BITS, default 8, brightness resolution (4..12).
REQ-003 Parameter PRESCALE, default 50000, clk cycles per blink tick (>=2).
REQ-004 Port clk  in  1  sole clock; every register samples on its rising edge.
REQ-005 Port reset_n  in  1  reset, asynchronous assert, active-low; not synchronised inside the block.
REQ-006 Port address  in  3  Avalon-MM word address.
REQ-007 Port chipselect  in  1  Avalon-MM slave select.
REQ-008 Port write_n  in  1  Avalon-MM write strobe, active-low.
REQ-009 Port writedata  in  32  Avalon-MM write data.
REQ-010 Port readdata  out  32  Avalon-MM read data; zero wait states; unused bits 0.
REQ-011 Port out_port  out  NUM_LEDS  LED drive, registered, 1 = lit.

Function
REQ-012 Register map: 0 DATA (RW, [NUM_LEDS-1:0]); 1 SET (WO, write-1-to-set DATA); 2 CLEAR (WO, write-1-to-clear DATA); 3 MODE (RW, per channel: 0 steady, 1 blink); 4 PERIOD (RW, [15:0], blink half-period in ticks); 5 DUTY (RW, [PWM_BITS-1:0], global brightness).
REQ-013 Write occurs when chipselect=1 and write_n=0; target register updates on that clk edge.
REQ-014 readdata is combinational from address; SET, CLEAR, and addresses 6-7 read 0; writes to 6-7 are ignored.
REQ-015 Prescaler counts 0..PRESCALE-1 and wraps; tick pulses for one cycle when it equals PRESCALE-1.
REQ-016 Blink counter increments on tick; when it equals PERIOD-1 on a tick, it returns to 0 and phase toggles.
REQ-017 PERIOD=0 freezes phase at 1 (blink channels then behave as steady).
REQ-018 Any PERIOD write clears the blink counter and prescaler and sets phase=1 on the same edge.
REQ-019 PWM counter is free-running, PWM_BITS wide, increments every cycle, and wraps from all-ones to 0.
REQ-020 pwm_on = 1 if DUTY is all-ones, else (pwm_cnt < DUTY); DUTY=0 keeps every LED dark.
REQ-021 Next out_port[i] = DATA[i] & (~MODE[i] | phase) & pwm_on.
REQ-022 Latency: a register write on edge t shows on out_port from edge t+1, with no glitch between edges.
REQ-023 All channels share phase and pwm_on, so they switch in lock-step.
REQ-024 writedata bits above a register's width are ignored.

Reset
REQ-025 Reset values: DATA=0, MODE=0, PERIOD=0, DUTY=all-ones, prescaler=0, blink counter=0, phase=1, pwm_cnt=0, out_port=0.
REQ-026 Reset asserted mid-blink or mid-PWM forces every state element to its reset value immediately, with no clock needed; operation resumes from reset state on the first edge after deassertion.

Structure
REQ-027 Register address constants (DATA..DUTY) and the default parameter values belong in the shared wasca package.
REQ-028 A single sub-module, wasca_led_pwm_gen, holds the prescaler, blink counter/phase and PWM counter and outputs tick, phase and pwm_on; the top holds the registers and the output mux.

Verification
REQ-029 Reset, then write DATA=0x15 -> out_port=0x15 one cycle after the write; read addr 0 returns 0x15.
REQ-030 DATA=0x1F, write SET=0x00 then CLEAR=0x0A -> DATA reads 0x15; reads of addr 1 and 2 return 0.
REQ-031 PRESCALE=4, DATA=0x01, MODE=0x01, PERIOD=2 -> out_port[0] toggles every 8 cycles; PERIOD=0 -> held lit.
REQ-032 PWM_BITS=4, DUTY=4, DATA=0x1F -> out_port=0x1F for 4 of every 16 cycles; DUTY=0 -> always 0; DUTY=15 -> always 0x1F.
REQ-033 Assert reset_n mid-blink between clock edges -> out_port=0 immediately; after release DATA, MODE and PERIOD read 0 and DUTY reads all-ones.
REQ-034 Write to addresses 6 and 7 with 0xFFFFFFFF -> no register changes; reads of 6 and 7 return 0.
